// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch -- single-issue instruction fetch unit.
//
// Fetches one 16-bit instruction at a time from an 8-bit addressed instruction
// memory, holds it for the downstream stage until it is consumed, and then
// advances the PC. A redirect (taken branch/jump) reloads the PC from
// RedirectPC and drops whatever was in flight. Opcode 4'hF (HALT) stops
// fetching until the next redirect or reset.
//
// Optional feature (compile-time macro IF_TIMEOUT_EN):
//   When defined, 16 consecutive FETCH cycles without ImemValid set the sticky
//   FetchErr flag and halt the unit. When undefined, FETCH waits forever and
//   FetchErr is tied low.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   ImemAddr   out  8   fetch address (always the internal PC)
//   ImemReq    out  1   fetch request, high only while fetching
//   ImemData   in   16  instruction word, sampled when ImemReq && ImemValid
//   ImemValid  in   1   memory response strobe
//   Stall      in   1   downstream hold; issued instruction not consumed
//   Redirect   in   1   branch/jump taken, one-cycle pulse
//   RedirectPC in   8   redirect target, valid with Redirect
//   Instr      out  16  issued instruction
//   Opcode     out  4   Instr[15:12]
//   InstrValid out  1   Instr/Opcode/IssuePC valid
//   IssuePC    out  8   address of the instruction in Instr
//   FetchErr   out  1   sticky fetch-timeout flag
// -----------------------------------------------------------------------------
module instr_fetch (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  ImemAddr,
  output logic        ImemReq,
  input  logic [15:0] ImemData,
  input  logic        ImemValid,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [7:0]  RedirectPC,
  output logic [15:0] Instr,
  output logic [3:0]  Opcode,
  output logic        InstrValid,
  output logic [7:0]  IssuePC,
  output logic        FetchErr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_e;

  localparam logic [3:0] OP_HALT = 4'hF;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  issue_pc_q, issue_pc_d;
  logic        valid_q, valid_d;

`ifdef IF_TIMEOUT_EN
  localparam logic [3:0] TMO_LAST = 4'd15;  // 16th consecutive empty cycle
  logic [3:0]  tmo_cnt_q, tmo_cnt_d;
  logic        fetch_err_q, fetch_err_d;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so the block can
    // never infer a latch on a path that forgets to assign it.
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    issue_pc_d = issue_pc_q;
    valid_d    = valid_q;
`ifdef IF_TIMEOUT_EN
    // Counter only survives while staying in FETCH without a response; every
    // other path (entering FETCH, redirect, response) restarts it from zero.
    tmo_cnt_d   = '0;
    fetch_err_d = fetch_err_q;
`endif

    if (state_q == IDLE) begin
      // Redirect is meaningless before the first fetch; just start.
      state_d = FETCH;
    end else if (Redirect) begin
      // Redirect beats response, stall and consume in the same cycle.
      pc_d    = RedirectPC;
      valid_d = 1'b0;
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (ImemValid) begin
            instr_d    = ImemData;
            issue_pc_d = pc_q;
            valid_d    = 1'b1;
            state_d    = ISSUE;
          end else begin
`ifdef IF_TIMEOUT_EN
            if (tmo_cnt_q == TMO_LAST) begin
              fetch_err_d = 1'b1;
              state_d     = HALTED;
            end else begin
              tmo_cnt_d = tmo_cnt_q + 4'd1;
            end
`endif
          end
        end
        ISSUE: begin
          if (!Stall) begin
            valid_d = 1'b0;
            // A consumed HALT parks the PC on itself.
            if (instr_q[15:12] == OP_HALT) begin
              state_d = HALTED;
            end else begin
              pc_d    = pc_q + 8'd1;  // 8-bit add wraps 0xFF -> 0x00
              state_d = FETCH;
            end
          end
        end
        default: ;  // HALTED: only Redirect (above) or reset leaves
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      issue_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      issue_pc_q <= issue_pc_d;
      valid_q    <= valid_d;
    end
  end

`ifdef IF_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q   <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign FetchErr = fetch_err_q;
`else
  assign FetchErr = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ImemAddr   = pc_q;
  assign ImemReq    = (state_q == FETCH);
  assign Instr      = instr_q;
  assign Opcode     = instr_q[15:12];
  assign InstrValid = valid_q;
  assign IssuePC    = issue_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch -- self-checking bench for instr_fetch.
// Directed scenarios compare against fixed expected values; the random
// scenario compares every cycle against a behavioural model that tracks the
// fetch unit as "started / halted / holding an instruction" flags.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ImemAddr;
  logic        ImemReq;
  logic [15:0] ImemData;
  logic        ImemValid;
  logic        Stall;
  logic        Redirect;
  logic [7:0]  RedirectPC;
  logic [15:0] Instr;
  logic [3:0]  Opcode;
  logic        InstrValid;
  logic [7:0]  IssuePC;
  logic        FetchErr;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ImemAddr   (ImemAddr),
    .ImemReq    (ImemReq),
    .ImemData   (ImemData),
    .ImemValid  (ImemValid),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .Instr      (Instr),
    .Opcode     (Opcode),
    .InstrValid (InstrValid),
    .IssuePC    (IssuePC),
    .FetchErr   (FetchErr)
  );

  always #5 clk = ~clk;

  // Hold reset two cycles, release on a falling edge; unit is then in IDLE.
  task automatic do_reset();
    rst_n      = 1'b0;
    ImemValid  = 1'b0;
    ImemData   = '0;
    Stall      = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [38:0] all_out;
    do_reset();
    @(negedge clk);                       // now FETCH at 0x00
    ImemValid = 1'b1; ImemData = 16'h5A5A; Stall = 1'b1;
    @(negedge clk);                       // captured, held in ISSUE
    ImemValid = 1'b0;
    n_checks++;
    if (InstrValid !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_valid: got %b want 1", InstrValid);
    end
    // Assert reset between edges together with a redirect: reset must win
    // immediately without waiting for a clock.
    #2;
    rst_n = 1'b0; Redirect = 1'b1; RedirectPC = 8'h33;
    #1;
    all_out = {ImemAddr, ImemReq, Instr, Opcode, InstrValid, IssuePC, FetchErr};
    n_checks++;
    if (all_out !== 39'd0) begin
      n_fail++; $display("FAIL reset_async_outputs: got %h want 0", all_out);
    end
    @(posedge clk); #1;
    all_out = {ImemAddr, ImemReq, Instr, Opcode, InstrValid, IssuePC, FetchErr};
    n_checks++;
    if (all_out !== 39'd0) begin
      n_fail++; $display("FAIL reset_beats_redirect: got %h want 0", all_out);
    end
    Redirect = 1'b0; Stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ImemReq !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_req: got %b want 0", ImemReq);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({ImemReq, ImemAddr} !== {1'b1, 8'h00}) begin
      n_fail++; $display("FAIL reset_first_fetch: got req=%b addr=%h want req=1 addr=00", ImemReq, ImemAddr);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_basic_fetch();
    do_reset();
    @(posedge clk);
    @(negedge clk);
    ImemValid = 1'b1; ImemData = 16'h6123;
    @(negedge clk);
    ImemValid = 1'b0; Stall = 1'b0;
    n_checks++;
    if ({Instr, Opcode, IssuePC, InstrValid, ImemReq} !== {16'h6123, 4'h6, 8'h00, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL basic_issue: got instr=%h op=%h pc=%h v=%b req=%b want 6123 6 00 1 0",
                         Instr, Opcode, IssuePC, InstrValid, ImemReq);
    end
    @(negedge clk);
    n_checks++;
    if ({ImemAddr, InstrValid, ImemReq} !== {8'h01, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL basic_consume: got addr=%h v=%b req=%b want 01 0 1", ImemAddr, InstrValid, ImemReq);
    end
  endtask

  // Continues from FETCH at 0x01.
  task automatic test_stall();
    ImemValid = 1'b1; ImemData = 16'h7ABC; Stall = 1'b1;
    @(negedge clk);
    ImemValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({Instr, Opcode, IssuePC, InstrValid, ImemReq, ImemAddr} !==
          {16'h7ABC, 4'h7, 8'h01, 1'b1, 1'b0, 8'h01}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got instr=%h op=%h ipc=%h v=%b req=%b addr=%h",
                           i, Instr, Opcode, IssuePC, InstrValid, ImemReq, ImemAddr);
      end
      @(negedge clk);
    end
    Stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ImemAddr, InstrValid, ImemReq} !== {8'h02, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL stall_release: got addr=%h v=%b req=%b want 02 0 1", ImemAddr, InstrValid, ImemReq);
    end
  endtask

  // Continues from FETCH at 0x02.
  task automatic test_redirect();
    ImemValid = 1'b1; ImemData = 16'h1234; Redirect = 1'b1; RedirectPC = 8'h40;
    @(negedge clk);
    ImemValid = 1'b0; Redirect = 1'b0;
    n_checks++;
    if ({InstrValid, ImemAddr, ImemReq, Instr} !== {1'b0, 8'h40, 1'b1, 16'h7ABC}) begin
      n_fail++; $display("FAIL redirect_vs_valid: got v=%b addr=%h req=%b instr=%h want 0 40 1 7abc",
                         InstrValid, ImemAddr, ImemReq, Instr);
    end
    // Redirect while a stalled instruction is held.
    ImemValid = 1'b1; ImemData = 16'h3456; Stall = 1'b1;
    @(negedge clk);
    ImemValid = 1'b0; Redirect = 1'b1; RedirectPC = 8'h41;
    @(negedge clk);
    Redirect = 1'b0; Stall = 1'b0;
    n_checks++;
    if ({InstrValid, ImemAddr, ImemReq} !== {1'b0, 8'h41, 1'b1}) begin
      n_fail++; $display("FAIL redirect_in_issue: got v=%b addr=%h req=%b want 0 41 1", InstrValid, ImemAddr, ImemReq);
    end
  endtask

  // Continues from FETCH at 0x41.
  task automatic test_wrap();
    Redirect = 1'b1; RedirectPC = 8'hFF;
    @(negedge clk);
    Redirect = 1'b0; ImemValid = 1'b1; ImemData = 16'h2000;
    @(negedge clk);
    ImemValid = 1'b0;
    n_checks++;
    if ({IssuePC, InstrValid} !== {8'hFF, 1'b1}) begin
      n_fail++; $display("FAIL wrap_issue: got ipc=%h v=%b want ff 1", IssuePC, InstrValid);
    end
    @(negedge clk);
    n_checks++;
    if ({ImemAddr, ImemReq} !== {8'h00, 1'b1}) begin
      n_fail++; $display("FAIL wrap_pc: got addr=%h req=%b want 00 1", ImemAddr, ImemReq);
    end
  endtask

  // Continues from FETCH at 0x00.
  task automatic test_halt();
    ImemValid = 1'b1; ImemData = 16'hF000;
    @(negedge clk);
    ImemValid = 1'b0;
    n_checks++;
    if (Opcode !== 4'hF) begin
      n_fail++; $display("FAIL halt_opcode: got %h want f", Opcode);
    end
    @(negedge clk);
    n_checks++;
    if ({ImemReq, InstrValid, ImemAddr} !== {1'b0, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL halt_enter: got req=%b v=%b addr=%h want 0 0 00", ImemReq, InstrValid, ImemAddr);
    end
    ImemValid = 1'b1; ImemData = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ImemReq, InstrValid, ImemAddr} !== {1'b0, 1'b0, 8'h00}) begin
        n_fail++; $display("FAIL halt_stays[%0d]: got req=%b v=%b addr=%h want 0 0 00", i, ImemReq, InstrValid, ImemAddr);
      end
    end
    ImemValid = 1'b0; Redirect = 1'b1; RedirectPC = 8'h10;
    @(negedge clk);
    Redirect = 1'b0;
    n_checks++;
    if ({ImemReq, ImemAddr} !== {1'b1, 8'h10}) begin
      n_fail++; $display("FAIL halt_resume: got req=%b addr=%h want 1 10", ImemReq, ImemAddr);
    end
    ImemValid = 1'b1; ImemData = 16'h2222;
    @(negedge clk);
    ImemValid = 1'b0;
    n_checks++;
    if ({Instr, IssuePC, InstrValid} !== {16'h2222, 8'h10, 1'b1}) begin
      n_fail++; $display("FAIL halt_refetch: got instr=%h ipc=%h v=%b want 2222 10 1", Instr, IssuePC, InstrValid);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    do_reset();
    @(posedge clk);                       // IDLE -> FETCH
    @(negedge clk);
    repeat (15) @(negedge clk);           // 15 empty FETCH cycles
    n_checks++;
    if ({FetchErr, ImemReq} !== 2'b01) begin
      n_fail++; $display("FAIL timeout_15: got err=%b req=%b want 0 1", FetchErr, ImemReq);
    end
    @(negedge clk);                       // 16th empty FETCH cycle
`ifdef IF_TIMEOUT_EN
    n_checks++;
    if ({FetchErr, ImemReq} !== 2'b10) begin
      n_fail++; $display("FAIL timeout_16: got err=%b req=%b want 1 0", FetchErr, ImemReq);
    end
    Redirect = 1'b1; RedirectPC = 8'h20;
    @(negedge clk);
    Redirect = 1'b0;
    n_checks++;
    if ({FetchErr, ImemReq, ImemAddr} !== {1'b1, 1'b1, 8'h20}) begin
      n_fail++; $display("FAIL timeout_sticky: got err=%b req=%b addr=%h want 1 1 20", FetchErr, ImemReq, ImemAddr);
    end
`else
    repeat (10) @(negedge clk);
    n_checks++;
    if ({FetchErr, ImemReq} !== 2'b01) begin
      n_fail++; $display("FAIL no_timeout: got err=%b req=%b want 0 1", FetchErr, ImemReq);
    end
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Random traffic against a behavioural model.
  task automatic test_random();
    bit          m_run, m_valid, m_halt, m_err;
    logic [7:0]  m_pc, m_ipc;
    logic [15:0] m_instr;
    int          m_wait;
    bit          n_run, n_valid, n_halt, n_err;
    logic [7:0]  n_pc, n_ipc;
    logic [15:0] n_instr;
    int          n_wait;
    logic        exp_req;

    do_reset();
    m_run = 0; m_valid = 0; m_halt = 0; m_err = 0;
    m_pc = '0; m_ipc = '0; m_instr = '0; m_wait = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      ImemValid  = ($urandom_range(0, 2) != 0);
      ImemData   = 16'($urandom);
      if ($urandom_range(0, 5) == 0) ImemData[15:12] = 4'hF;
      Stall      = ($urandom_range(0, 2) == 0);
      Redirect   = ($urandom_range(0, 7) == 0);
      RedirectPC = 8'($urandom);

      n_run = 1; n_valid = m_valid; n_halt = m_halt; n_err = m_err;
      n_pc = m_pc; n_ipc = m_ipc; n_instr = m_instr; n_wait = m_wait;
      if (!m_run) begin
        // first edge after reset only starts fetching
      end else if (Redirect) begin
        n_pc = RedirectPC; n_valid = 0; n_halt = 0; n_wait = 0;
      end else if (m_halt) begin
        // parked
      end else if (!m_valid) begin
        if (ImemValid) begin
          n_instr = ImemData; n_ipc = m_pc; n_valid = 1; n_wait = 0;
        end else begin
          n_wait = m_wait + 1;
`ifdef IF_TIMEOUT_EN
          if (n_wait == 16) begin n_err = 1; n_halt = 1; end
`endif
        end
      end else if (!Stall) begin
        n_valid = 0; n_wait = 0;
        if (m_instr[15:12] == 4'hF) n_halt = 1;
        else n_pc = m_pc + 8'd1;
      end

      @(posedge clk);
      m_run = n_run; m_valid = n_valid; m_halt = n_halt; m_err = n_err;
      m_pc = n_pc; m_ipc = n_ipc; m_instr = n_instr; m_wait = n_wait;
      @(negedge clk);

      exp_req = m_run && !m_halt && !m_valid;
      n_checks++;
      if ({ImemAddr, ImemReq, InstrValid, FetchErr} !== {m_pc, exp_req, m_valid, m_err}) begin
        n_fail++; $display("FAIL rand_ctrl[%0d]: got addr=%h req=%b v=%b err=%b want %h %b %b %b",
                           cyc, ImemAddr, ImemReq, InstrValid, FetchErr, m_pc, exp_req, m_valid, m_err);
      end
      if (m_valid) begin
        n_checks++;
        if ({Instr, Opcode, IssuePC} !== {m_instr, m_instr[15:12], m_ipc}) begin
          n_fail++; $display("FAIL rand_issue[%0d]: got instr=%h op=%h ipc=%h want %h %h %h",
                             cyc, Instr, Opcode, IssuePC, m_instr, m_instr[15:12], m_ipc);
        end
      end
    end
    ImemValid = 1'b0; Stall = 1'b0; Redirect = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst_n      = 1'b0;
    ImemValid  = 1'b0;
    ImemData   = '0;
    Stall      = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = '0;

    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_timeout();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
